// File: rtl/src_datapath_pkg.sv
// Shared constants for the src_datapath slice: data width, ALU operation codes and bus source codes.
// Optional MUL/DIV hardware is controlled by the macro SRC_DATAPATH_MULDIV_EN (see src_alu).
package src_datapath_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_SHR  = 4'b0100,
        OP_SHRA = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_ROR  = 4'b0111,
        OP_ROL  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_DIV  = 4'b1010,
        OP_NEG  = 4'b1011,
        OP_NOT  = 4'b1100
    } alu_op_e;

    // Codes 00000-01111 select R0-R15 directly; these cover the special sources.
    typedef enum logic [4:0] {
        SEL_HI  = 5'b10000,
        SEL_LO  = 5'b10001,
        SEL_ZHI = 5'b10010,
        SEL_ZLO = 5'b10011,
        SEL_PC  = 5'b10100,
        SEL_MDR = 5'b10101
    } bus_sel_e;

    function automatic logic [2*DATA_W-1:0] low_word(input logic [DATA_W-1:0] value);
        return {{DATA_W{1'b0}}, value};
    endfunction

endpackage

// File: rtl/src_alu.sv
// Combinational ALU: A=Y, B=bus, 64-bit result destined for Z.
// MUL/DIV logic is only built when SRC_DATAPATH_MULDIV_EN is defined; otherwise those ops return 0.
module src_alu
    import src_datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [3:0]          op,
    input  logic                incPC,
    output logic [2*DATA_W-1:0] result
);

    alu_op_e               op_e;
    logic [4:0]            shamt;
    logic [2*DATA_W-1:0]   rot_r;
    logic [2*DATA_W-1:0]   rot_l;

    assign op_e  = alu_op_e'(op);
    assign shamt = B[4:0];
    // Rotating the doubled word avoids a shift by the full width when shamt is 0.
    assign rot_r = {A, A} >> shamt;
    assign rot_l = {A, A} << shamt;

`ifdef SRC_DATAPATH_MULDIV_EN
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] product;
    logic signed [DATA_W-1:0]   quotient;
    logic signed [DATA_W-1:0]   remainder;

    assign a_ext   = {{DATA_W{A[DATA_W-1]}}, A};
    assign b_ext   = {{DATA_W{B[DATA_W-1]}}, B};
    assign product = a_ext * b_ext;

    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (B == '0) begin
            quotient  = '1;
            remainder = $signed(A);
        end else if (A == {1'b1, {(DATA_W-1){1'b0}}} && B == '1) begin
            // Most-negative / -1 overflows; the wrapped quotient is A itself.
            quotient  = $signed(A);
            remainder = '0;
        end else begin
            quotient  = $signed(A) / $signed(B);
            remainder = $signed(A) % $signed(B);
        end
    end
`endif

    always_comb begin
        result = '0;
        if (incPC) begin
            result = low_word(B + 1'b1);
        end else begin
            case (op_e)
                OP_AND:  result = low_word(A & B);
                OP_OR:   result = low_word(A | B);
                OP_ADD:  result = low_word(A + B);
                OP_SUB:  result = low_word(A - B);
                OP_SHR:  result = low_word(A >> shamt);
                OP_SHRA: result = low_word($unsigned($signed(A) >>> shamt));
                OP_SHL:  result = low_word(A << shamt);
                OP_ROR:  result = low_word(rot_r[DATA_W-1:0]);
                OP_ROL:  result = low_word(rot_l[2*DATA_W-1:DATA_W]);
`ifdef SRC_DATAPATH_MULDIV_EN
                OP_MUL:  result = $unsigned(product);
                OP_DIV:  result = {$unsigned(remainder), $unsigned(quotient)};
`endif
                OP_NEG:  result = low_word(-B);
                OP_NOT:  result = low_word(~B);
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/src_datapath.sv
// Single-bus datapath: register file, special registers, bus mux and the src_alu instance.
// Build with SRC_DATAPATH_MULDIV_EN defined to include MUL/DIV hardware in the ALU.
module src_datapath
    import src_datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              MDR_read,
    input  logic              e_PC,
    input  logic              e_IR,
    input  logic              e_Y,
    input  logic              e_Z,
    input  logic              e_HI,
    input  logic              e_LO,
    input  logic              e_MDR,
    input  logic              e_MAR,
    input  logic              e_GP,
    input  logic [3:0]        GP_addr,
    input  logic              incPC,
    input  logic [3:0]        ALU_op,
    input  logic [4:0]        BusDataSelect,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mar_out
);

    logic [DATA_W-1:0]   pc_q, ir_q, y_q, hi_q, lo_q, mdr_q, mar_q;
    logic [2*DATA_W-1:0] z_q;
    logic [DATA_W-1:0]   gpr_q [16];
    logic [DATA_W-1:0]   bus;
    logic [2*DATA_W-1:0] alu_result;

    always_comb begin
        bus = '0;
        if (!BusDataSelect[4]) begin
            bus = gpr_q[BusDataSelect[3:0]];
        end else begin
            case (bus_sel_e'(BusDataSelect))
                SEL_HI:  bus = hi_q;
                SEL_LO:  bus = lo_q;
                SEL_ZHI: bus = z_q[2*DATA_W-1:DATA_W];
                SEL_ZLO: bus = z_q[DATA_W-1:0];
                SEL_PC:  bus = pc_q;
                SEL_MDR: bus = mdr_q;
                default: bus = '0;
            endcase
        end
    end

    src_alu u_alu (
        .A      (y_q),
        .B      (bus),
        .op     (ALU_op),
        .incPC  (incPC),
        .result (alu_result)
    );

    // Every enabled register samples the same pre-edge bus, so simultaneous loads never conflict.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mdr_q <= '0;
            mar_q <= '0;
            // NOTE: the register file is architecturally cleared, so it is built from flops, not a RAM macro.
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
        end else begin
            if (e_PC)  pc_q  <= bus;
            if (e_IR)  ir_q  <= bus;
            if (e_Y)   y_q   <= bus;
            if (e_Z)   z_q   <= alu_result;
            if (e_HI)  hi_q  <= bus;
            if (e_LO)  lo_q  <= bus;
            if (e_MAR) mar_q <= bus;
            if (e_MDR) mdr_q <= MDR_read ? Mdatain : bus;
            if (e_GP)  gpr_q[GP_addr] <= bus;
        end
    end

    assign bus_out = bus;
    assign pc_out  = pc_q;
    assign ir_out  = ir_q;
    assign mar_out = mar_q;

endmodule

// File: tb/tb_src_datapath.sv
// Directed self-checking bench for src_datapath: AND flow, fetch, ALU ops, multi-load and async clear.
// MUL/DIV expectations follow SRC_DATAPATH_MULDIV_EN (zero when the feature is not built).
module tb_src_datapath;
    import src_datapath_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic [3:0]  GP_addr;
    logic        incPC;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic [31:0] bus_out, pc_out, ir_out, mar_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    src_datapath dut (
        .clock         (clock),
        .clear         (clear),
        .Mdatain       (Mdatain),
        .MDR_read      (MDR_read),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .e_MDR         (e_MDR),
        .e_MAR         (e_MAR),
        .e_GP          (e_GP),
        .GP_addr       (GP_addr),
        .incPC         (incPC),
        .ALU_op        (ALU_op),
        .BusDataSelect (BusDataSelect),
        .bus_out       (bus_out),
        .pc_out        (pc_out),
        .ir_out        (ir_out),
        .mar_out       (mar_out)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        Mdatain = '0; MDR_read = 1'b0;
        e_PC = 1'b0; e_IR = 1'b0; e_Y = 1'b0; e_Z = 1'b0; e_HI = 1'b0;
        e_LO = 1'b0; e_MDR = 1'b0; e_MAR = 1'b0; e_GP = 1'b0;
        GP_addr = '0; incPC = 1'b0; ALU_op = '0; BusDataSelect = 5'b11111;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read a bus source combinationally.
    task automatic peek(input string tag, input logic [4:0] sel, input logic [31:0] expected);
        BusDataSelect = sel;
        #1;
        check(tag, bus_out, expected);
    endtask

    // Mdatain -> MDR -> R[idx]
    task automatic load_gp(input logic [3:0] idx, input logic [31:0] value);
        idle(); Mdatain = value; MDR_read = 1'b1; e_MDR = 1'b1; tick();
        idle(); BusDataSelect = SEL_MDR; GP_addr = idx; e_GP = 1'b1; tick();
        idle();
    endtask

    task automatic alu_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        load_gp(4'd1, a);
        load_gp(4'd2, b);
        idle(); BusDataSelect = 5'd1; e_Y = 1'b1; tick();
        idle(); BusDataSelect = 5'd2; ALU_op = op; e_Z = 1'b1; tick();
        idle();
        peek({tag, "_zhi"}, SEL_ZHI, exp_hi);
        peek({tag, "_zlo"}, SEL_ZLO, exp_lo);
    endtask

    initial begin
        idle();
        clear = 1'b1;
        tick(); tick();
        check("rst_pc", pc_out, 32'h0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_mar", mar_out, 32'h0);
        peek("rst_r5", 5'd5, 32'h0);
        peek("rst_zlo", SEL_ZLO, 32'h0);
        #2 clear = 1'b0;

        // AND flow
        load_gp(4'd3, 32'h22);
        load_gp(4'd7, 32'h24);
        load_gp(4'd4, 32'h28);
        peek("ld_r3", 5'd3, 32'h22);
        peek("ld_r7", 5'd7, 32'h24);
        peek("ld_r4", 5'd4, 32'h28);
        idle(); BusDataSelect = 5'd3; e_Y = 1'b1; tick();
        idle(); BusDataSelect = 5'd7; ALU_op = OP_AND; e_Z = 1'b1; tick();
        idle(); BusDataSelect = SEL_ZLO; GP_addr = 4'd4; e_GP = 1'b1; tick();
        idle();
        peek("and_r4", 5'd4, 32'h20);
        peek("and_zhi", SEL_ZHI, 32'h0);

        // Fetch from PC=0
        idle(); BusDataSelect = SEL_PC; e_MAR = 1'b1; incPC = 1'b1; ALU_op = OP_SUB; e_Z = 1'b1; tick();
        check("t0_mar", mar_out, 32'h0);
        idle(); BusDataSelect = SEL_ZLO; e_PC = 1'b1; e_MDR = 1'b1; MDR_read = 1'b1;
        Mdatain = 32'h2A2B8000; tick();
        check("t1_pc", pc_out, 32'h1);
        idle(); BusDataSelect = SEL_MDR; e_IR = 1'b1; tick();
        check("t2_ir", ir_out, 32'h2A2B8000);
        check("t2_mar", mar_out, 32'h0);

        // Async clear mid-sequence, checked before the next edge
        idle(); BusDataSelect = 5'd4; #1;
        check("pre_clr_r4", bus_out, 32'h20);
        clear = 1'b1; #1;
        check("clr_bus_r4", bus_out, 32'h0);
        check("clr_pc", pc_out, 32'h0);
        check("clr_ir", ir_out, 32'h0);
        check("clr_mar", mar_out, 32'h0);
        peek("clr_mdr", SEL_MDR, 32'h0);
        peek("clr_r3", 5'd3, 32'h0);
        tick();
        clear = 1'b0;

        // ALU operations (Y=A, bus=B)
`ifdef SRC_DATAPATH_MULDIV_EN
        alu_run("mul", 32'hFFFFFFFF, 32'h2, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFE);
        alu_run("div", 32'h7, 32'h2, OP_DIV, 32'h1, 32'h3);
        alu_run("div0", 32'h7, 32'h0, OP_DIV, 32'h7, 32'hFFFFFFFF);
        alu_run("divneg", 32'hFFFFFFF9, 32'h2, OP_DIV, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
        alu_run("mul_off", 32'hFFFFFFFF, 32'h2, OP_MUL, 32'h0, 32'h0);
        alu_run("div_off", 32'h7, 32'h2, OP_DIV, 32'h0, 32'h0);
        alu_run("div0_off", 32'h7, 32'h0, OP_DIV, 32'h0, 32'h0);
`endif
        alu_run("shra", 32'h80000001, 32'h1, OP_SHRA, 32'h0, 32'hC0000000);
        alu_run("rol", 32'h80000001, 32'h1, OP_ROL, 32'h0, 32'h00000003);
        alu_run("shr", 32'h80000001, 32'h1, OP_SHR, 32'h0, 32'h40000000);
        alu_run("ror", 32'h80000001, 32'h1, OP_ROR, 32'h0, 32'hC0000000);
        alu_run("shl", 32'h80000001, 32'h1, OP_SHL, 32'h0, 32'h00000002);
        alu_run("shl0", 32'h80000001, 32'h20, OP_SHL, 32'h0, 32'h80000001);
        alu_run("ror0", 32'h12345678, 32'h0, OP_ROR, 32'h0, 32'h12345678);
        alu_run("add", 32'hFFFFFFFF, 32'h2, OP_ADD, 32'h0, 32'h00000001);
        alu_run("sub", 32'h1, 32'h2, OP_SUB, 32'h0, 32'hFFFFFFFF);
        alu_run("or", 32'hF0, 32'h0F, OP_OR, 32'h0, 32'hFF);
        alu_run("neg", 32'h0, 32'h5, OP_NEG, 32'h0, 32'hFFFFFFFB);
        alu_run("not", 32'h0, 32'h0000FFFF, OP_NOT, 32'h0, 32'hFFFF0000);
        alu_run("op_d", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101, 32'h0, 32'h0);

        // Simultaneous loads from one bus value, plus HI/LO paths
        load_gp(4'd9, 32'hA5A5_0001);
        idle(); BusDataSelect = 5'd9; e_PC = 1'b1; e_IR = 1'b1; e_MAR = 1'b1; e_HI = 1'b1;
        e_MDR = 1'b1; MDR_read = 1'b0; Mdatain = 32'hDEADBEEF; tick();
        idle();
        check("multi_pc", pc_out, 32'hA5A50001);
        check("multi_ir", ir_out, 32'hA5A50001);
        check("multi_mar", mar_out, 32'hA5A50001);
        peek("multi_hi", SEL_HI, 32'hA5A50001);
        peek("multi_mdr", SEL_MDR, 32'hA5A50001);
        peek("lo_untouched", SEL_LO, 32'h0);
        idle(); BusDataSelect = SEL_HI; e_LO = 1'b1; tick();
        idle();
        peek("lo_from_hi", SEL_LO, 32'hA5A50001);
        peek("bus_unused", 5'b10110, 32'h0);
        peek("bus_unused_max", 5'b11111, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/src_datapath.md
SRC_DATAPATH -- requirements
Module: src_datapath

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high: clock (in, 1, rising-edge clock), clear (in, 1, async active-high reset).
REQ-002 SHALL have Mdatain (in, 32, memory read data) and MDR_read (in, 1, MDR source select: 1=Mdatain, 0=bus).
REQ-003 SHALL have register load enables e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP (in, 1 each).
REQ-004 SHALL have GP_addr (in, 4, general-register write index R0..R15) and incPC (in, 1, ALU forced to bus+1).
REQ-005 SHALL have ALU_op (in, 4, operation code) and BusDataSelect (in, 5, bus source).
REQ-006 SHALL have bus_out, pc_out, ir_out and mar_out (out, 32 each, current bus value and register contents).

Function
REQ-007 SHALL drive a combinational 32-bit bus: BusDataSelect 00000-01111 = R0-R15, 10000=HI, 10001=LO, 10010=Zhigh, 10011=Zlow, 10100=PC, 10101=MDR, any other code=0.
REQ-008 SHALL, on rising clock with e_X=1, load register X from the bus; X is one of PC, IR, Y, HI, LO, MAR, or R[GP_addr] for e_GP.
REQ-009 SHALL load MDR from Mdatain when e_MDR=1 and MDR_read=1, and from the bus when e_MDR=1 and MDR_read=0.
REQ-010 SHALL load 64-bit Z (Zhigh:Zlow) from the ALU result when e_Z=1.
REQ-011 SHALL take ALU operands A=Y and B=bus.
REQ-012 SHALL, when incPC=1, make the ALU result {32'h0, B+1} regardless of ALU_op.
REQ-013 SHALL implement ALU_op codes 0000 AND, 0001 OR, 0010 ADD, 0011 SUB (A-B), 0100 SHR, 0101 SHRA, 0110 SHL, 0111 ROR, 1000 ROL, 1001 MUL, 1010 DIV, 1011 NEG (-B), 1100 NOT (~B); codes 1101-1111 give 0.
REQ-014 SHALL, for every single-word operation, put the result in Zlow and set Zhigh=0; ADD/SUB wrap modulo 2^32.
REQ-015 SHALL shift or rotate A by B[4:0] for SHR/SHRA/SHL/ROR/ROL; an amount of 0 passes A unchanged.
REQ-016 SHALL compute MUL as a signed 32x32 product, full 64 bits into Z.
REQ-017 SHALL compute DIV as signed, with Zlow=quotient and Zhigh=remainder.
REQ-018 SHALL, for DIV with B=0, give Zlow=32'hFFFFFFFF and Zhigh=A.
REQ-019 SHALL load every enabled register from the same pre-edge bus value when several enables are high in one cycle; there is no priority and no conflict.
REQ-020 SHALL have single-cycle latency for all register loads; the ALU is purely combinational.

Reset
REQ-021 SHALL, while clear=1, asynchronously force PC, IR, Y, Z, HI, LO, MDR, MAR and R0-R15 to 0, overriding all enables.
REQ-022 SHALL resume normal loading on the first rising edge after clear deasserts; clear mid-sequence discards all operands.

Configuration
REQ-023 SHALL compile the MUL and DIV hardware only when macro SRC_DATAPATH_MULDIV_EN is defined; without it, ops 1001/1010 yield Z=0 and no multiplier or divider is synthesized.

Structure
REQ-024 SHALL place ALU_op codes, BusDataSelect codes and the 32-bit data width constant in shared package src_datapath_pkg.
REQ-025 SHALL implement the ALU as one sub-module src_alu (inputs A, B, op, incPC; output 64-bit result); registers and bus mux live in src_datapath.

Verification
REQ-026 SHALL test the AND flow: load R3=0x22, R7=0x24, R4=0x28 via Mdatain->MDR->GP, then Y<=R3, ALU_op=0000 with bus=R7, Zlow->R4 -> R4=0x20.
REQ-027 SHALL test fetch from PC=0: T0 (bus=PC, e_MAR, incPC, e_Z) then T1 (bus=Zlow, e_PC, MDR_read with Mdatain=0x2A2B8000), then MDR->IR -> MAR=0, PC=1, ir_out=0x2A2B8000.
REQ-028 SHALL test MUL with Y=0xFFFFFFFF, bus=2 -> Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFFE.
REQ-029 SHALL test DIV: Y=7, bus=2 -> Zlow=3, Zhigh=1; Y=7, bus=0 -> Zlow=0xFFFFFFFF, Zhigh=7.
REQ-030 SHALL test shift/rotate with Y=0x80000001, bus=1: SHRA -> 0xC0000000, ROL -> 0x00000003, SHR -> 0x40000000.
REQ-031 SHALL test reset: assert clear mid-sequence with R4=0x20 and PC=1 -> all registers and bus_out (select R4) read 0 immediately, before the next edge.
